// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: state encoding, default widths and
// the alignment rule for 16-bit memory accesses.
package mem_stage_pkg;

  localparam int MEM_DW = 16;
  localparam int MEM_RW = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Word accesses must be even; an odd address on a load/store is fatal.
  function automatic logic is_misaligned(input logic addr_lsb, input logic rd,
                                         input logic wr);
    return addr_lsb & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register: load captures a full writeback payload and sets
// valid, bubble only clears valid and leaves the payload untouched.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DW = MEM_DW,
  parameter int RW = MEM_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          bubble,
  input  logic [DW-1:0] d_memout,
  input  logic [DW-1:0] d_data,
  input  logic [DW-1:0] d_pcinc,
  input  logic          d_cond,
  input  logic          d_pctoreg,
  input  logic          d_memtoreg,
  input  logic          d_set,
  input  logic          d_regwrite,
  input  logic [RW-1:0] d_writereg,
  input  logic          d_halt,
  input  logic          d_err,
  output logic          wb_valid,
  output logic [DW-1:0] wb_memout,
  output logic [DW-1:0] wb_data,
  output logic [DW-1:0] wb_pcinc,
  output logic          wb_cond,
  output logic          wb_pctoreg,
  output logic          wb_memtoreg,
  output logic          wb_set,
  output logic          wb_regwrite,
  output logic [RW-1:0] wb_writereg,
  output logic          wb_halt,
  output logic          wb_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_memout   <= '0;
      wb_data     <= '0;
      wb_pcinc    <= '0;
      wb_cond     <= 1'b0;
      wb_pctoreg  <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_set      <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_writereg <= '0;
      wb_halt     <= 1'b0;
      wb_err      <= 1'b0;
    end else if (load) begin
      wb_valid    <= 1'b1;
      wb_memout   <= d_memout;
      wb_data     <= d_data;
      wb_pcinc    <= d_pcinc;
      wb_cond     <= d_cond;
      wb_pctoreg  <= d_pctoreg;
      wb_memtoreg <= d_memtoreg;
      wb_set      <= d_set;
      wb_regwrite <= d_regwrite;
      wb_writereg <= d_writereg;
      wb_halt     <= d_halt;
      wb_err      <= d_err;
    end else if (bubble) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores over a req/stall/done handshake, stalls
// upstream while an access is in flight, and feeds the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW      = MEM_DW,
  parameter int RW      = MEM_RW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [DW-1:0] in_pcinc,
  input  logic          in_cond,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic          in_pctoreg,
  input  logic          in_memtoreg,
  input  logic          in_set,
  input  logic          in_regwrite,
  input  logic [RW-1:0] in_writereg,
  input  logic          in_halt,
  input  logic          flush,
  output logic          stall_out,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_stall,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic [DW-1:0] wb_memout,
  output logic [DW-1:0] wb_data,
  output logic [DW-1:0] wb_pcinc,
  output logic          wb_cond,
  output logic          wb_pctoreg,
  output logic          wb_memtoreg,
  output logic          wb_set,
  output logic          wb_regwrite,
  output logic [RW-1:0] wb_writereg,
  output logic          wb_halt,
  output logic          wb_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt;

  logic [DW-1:0] hold_addr_p0, hold_wdata_p0, hold_pcinc_p0;
  logic          hold_cond_p0, hold_memread_p0, hold_memwrite_p0;
  logic          hold_pctoreg_p0, hold_memtoreg_p0, hold_set_p0;
  logic          hold_regwrite_p0, hold_halt_p0;
  logic [RW-1:0] hold_writereg_p0;

  logic          accept, mem_op;
  logic          load, bubble, capture, cnt_clr, cnt_inc, use_hold, ld_err;
  logic [DW-1:0] ld_memout;

  assign accept = in_valid & ~flush;
  assign mem_op = in_memread | in_memwrite;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    bubble    = 1'b0;
    capture   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    use_hold  = 1'b0;
    ld_err    = 1'b0;
    ld_memout = '0;
    case (state)
      ST_IDLE: begin
        if (!accept) begin
          bubble = 1'b1;
        end else if (!mem_op) begin
          load = 1'b1;
          if (in_halt) state_nxt = ST_HALTED;
        end else if (is_misaligned(in_addr[0], in_memread, in_memwrite)) begin
          load      = 1'b1;
          ld_err    = 1'b1;
          state_nxt = ST_HALTED;
        end else begin
          capture   = 1'b1;
          bubble    = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!mem_stall) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // done is only honoured here, never on the cycle the request is taken
        if (mem_done) begin
          load      = 1'b1;
          use_hold  = 1'b1;
          ld_memout = hold_memread_p0 ? mem_rdata : '0;
          state_nxt = ST_IDLE;
        end else if (cnt == CW'(TIMEOUT)) begin
          load      = 1'b1;
          use_hold  = 1'b1;
          ld_err    = 1'b1;
          state_nxt = ST_HALTED;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: bubble = 1'b1;
    endcase
  end

  // Control stage: FSM and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
    end
  end

  // Holding stage: EX/MEM contents kept stable for the whole access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr_p0     <= '0;
      hold_wdata_p0    <= '0;
      hold_pcinc_p0    <= '0;
      hold_cond_p0     <= 1'b0;
      hold_memread_p0  <= 1'b0;
      hold_memwrite_p0 <= 1'b0;
      hold_pctoreg_p0  <= 1'b0;
      hold_memtoreg_p0 <= 1'b0;
      hold_set_p0      <= 1'b0;
      hold_regwrite_p0 <= 1'b0;
      hold_writereg_p0 <= '0;
      hold_halt_p0     <= 1'b0;
    end else if (capture) begin
      hold_addr_p0     <= in_addr;
      hold_wdata_p0    <= in_wdata;
      hold_pcinc_p0    <= in_pcinc;
      hold_cond_p0     <= in_cond;
      hold_memread_p0  <= in_memread;
      hold_memwrite_p0 <= in_memwrite;
      hold_pctoreg_p0  <= in_pctoreg;
      hold_memtoreg_p0 <= in_memtoreg;
      hold_set_p0      <= in_set;
      hold_regwrite_p0 <= in_regwrite;
      hold_writereg_p0 <= in_writereg;
      hold_halt_p0     <= in_halt;
    end
  end

  assign stall_out = (state != ST_IDLE);
  assign mem_req   = (state == ST_REQ);
  assign mem_wr    = mem_req & hold_memwrite_p0;
  assign mem_addr  = mem_req ? hold_addr_p0  : '0;
  assign mem_wdata = mem_req ? hold_wdata_p0 : '0;

  // Writeback stage: payload from inputs (IDLE) or holding registers (WAIT)
  mem_wb_reg #(
    .DW (DW),
    .RW (RW)
  ) u_mem_wb_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .bubble      (bubble),
    .d_memout    (ld_memout),
    .d_data      (use_hold ? hold_addr_p0     : in_addr),
    .d_pcinc     (use_hold ? hold_pcinc_p0    : in_pcinc),
    .d_cond      (use_hold ? hold_cond_p0     : in_cond),
    .d_pctoreg   (use_hold ? hold_pctoreg_p0  : in_pctoreg),
    .d_memtoreg  (use_hold ? hold_memtoreg_p0 : in_memtoreg),
    .d_set       (use_hold ? hold_set_p0      : in_set),
    .d_regwrite  ((use_hold ? hold_regwrite_p0 : in_regwrite) & ~ld_err),
    .d_writereg  (use_hold ? hold_writereg_p0 : in_writereg),
    .d_halt      (use_hold ? hold_halt_p0     : in_halt),
    .d_err       (ld_err),
    .wb_valid    (wb_valid),
    .wb_memout   (wb_memout),
    .wb_data     (wb_data),
    .wb_pcinc    (wb_pcinc),
    .wb_cond     (wb_cond),
    .wb_pctoreg  (wb_pctoreg),
    .wb_memtoreg (wb_memtoreg),
    .wb_set      (wb_set),
    .wb_regwrite (wb_regwrite),
    .wb_writereg (wb_writereg),
    .wb_halt     (wb_halt),
    .wb_err      (wb_err)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshakes,
// misalignment, timeout, asynchronous reset and halt behaviour.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_addr, in_wdata, in_pcinc;
  logic        in_cond, in_memread, in_memwrite;
  logic        in_pctoreg, in_memtoreg, in_set, in_regwrite;
  logic [2:0]  in_writereg;
  logic        in_halt, flush;
  logic        stall_out, mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_stall, mem_done;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic [15:0] wb_memout, wb_data, wb_pcinc;
  logic        wb_cond, wb_pctoreg, wb_memtoreg, wb_set, wb_regwrite;
  logic [2:0]  wb_writereg;
  logic        wb_halt, wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_pcinc(in_pcinc), .in_cond(in_cond),
    .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_pctoreg(in_pctoreg), .in_memtoreg(in_memtoreg), .in_set(in_set),
    .in_regwrite(in_regwrite), .in_writereg(in_writereg), .in_halt(in_halt),
    .flush(flush), .stall_out(stall_out), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_memout(wb_memout), .wb_data(wb_data), .wb_pcinc(wb_pcinc),
    .wb_cond(wb_cond), .wb_pctoreg(wb_pctoreg), .wb_memtoreg(wb_memtoreg),
    .wb_set(wb_set), .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
    .wb_halt(wb_halt), .wb_err(wb_err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    in_valid = 0; in_addr = '0; in_wdata = '0; in_pcinc = '0; in_cond = 0;
    in_memread = 0; in_memwrite = 0; in_pctoreg = 0; in_memtoreg = 0;
    in_set = 0; in_regwrite = 0; in_writereg = '0; in_halt = 0; flush = 0;
  endtask

  task automatic reset_cycle;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    idle_in;
    mem_stall = 0; mem_done = 0; mem_rdata = '0;
    rst_n = 1'b0;
    repeat (2) tick;
    chk1("rst_stall", stall_out, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_wb_err", wb_err, 1'b0);
    chk16("rst_wb_data", wb_data, 16'h0000);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    rst_n = 1'b1;
    tick;

    // ALU op: one-cycle latency, no stall
    in_valid = 1; in_addr = 16'h1234; in_regwrite = 1; in_writereg = 3'd3;
    in_pcinc = 16'h0102;
    chk1("alu_stall_pre", stall_out, 1'b0);
    tick;
    chk1("alu_wb_valid", wb_valid, 1'b1);
    chk16("alu_wb_data", wb_data, 16'h1234);
    chk16("alu_wb_memout", wb_memout, 16'h0000);
    chk16("alu_wb_pcinc", wb_pcinc, 16'h0102);
    chk1("alu_wb_regwrite", wb_regwrite, 1'b1);
    chk1("alu_stall_post", stall_out, 1'b0);
    idle_in;
    tick;
    chk1("alu_bubble", wb_valid, 1'b0);

    // Load at 0x0040, done three cycles after the request is taken
    in_valid = 1; in_addr = 16'h0040; in_memread = 1; in_memtoreg = 1;
    in_regwrite = 1; in_writereg = 3'd5;
    tick;
    idle_in;
    chk1("ld_stall1", stall_out, 1'b1);
    chk1("ld_req1", mem_req, 1'b1);
    chk1("ld_wr", mem_wr, 1'b0);
    chk16("ld_addr", mem_addr, 16'h0040);
    chk1("ld_wb_valid_busy", wb_valid, 1'b0);
    tick;
    chk1("ld_stall2", stall_out, 1'b1);
    chk1("ld_req2", mem_req, 1'b0);
    tick;
    chk1("ld_stall3", stall_out, 1'b1);
    chk1("ld_req3", mem_req, 1'b0);
    tick;
    chk1("ld_stall4", stall_out, 1'b1);
    chk1("ld_req4", mem_req, 1'b0);
    mem_done = 1; mem_rdata = 16'hBEEF;
    tick;
    mem_done = 0; mem_rdata = '0;
    chk1("ld_wb_valid", wb_valid, 1'b1);
    chk16("ld_wb_memout", wb_memout, 16'hBEEF);
    chk16("ld_wb_data", wb_data, 16'h0040);
    chk1("ld_wb_memtoreg", wb_memtoreg, 1'b1);
    chk1("ld_stall_done", stall_out, 1'b0);

    // Store at 0x0010 with the memory stalling the request for two cycles
    in_valid = 1; in_addr = 16'h0010; in_wdata = 16'h00AA; in_memwrite = 1;
    mem_stall = 1;
    tick;
    idle_in;
    for (int i = 0; i < 3; i++) begin
      chk1("st_req", mem_req, 1'b1);
      chk1("st_wr", mem_wr, 1'b1);
      chk16("st_addr", mem_addr, 16'h0010);
      chk16("st_wdata", mem_wdata, 16'h00AA);
      if (i == 2) mem_stall = 0;
      tick;
    end
    chk1("st_req_taken", mem_req, 1'b0);
    chk1("st_stall_wait", stall_out, 1'b1);
    mem_done = 1;
    tick;
    mem_done = 0;
    chk1("st_wb_valid", wb_valid, 1'b1);
    chk1("st_wb_regwrite", wb_regwrite, 1'b0);
    chk16("st_wb_memout", wb_memout, 16'h0000);

    // Misaligned load: error, no request, halted
    in_valid = 1; in_addr = 16'h0041; in_memread = 1; in_regwrite = 1;
    tick;
    idle_in;
    chk1("mis_req", mem_req, 1'b0);
    chk1("mis_err", wb_err, 1'b1);
    chk1("mis_wb_valid", wb_valid, 1'b1);
    chk1("mis_regwrite", wb_regwrite, 1'b0);
    chk1("mis_stall", stall_out, 1'b1);
    tick;
    chk1("mis_stall2", stall_out, 1'b1);
    chk1("mis_wb_valid2", wb_valid, 1'b0);
    chk1("mis_req2", mem_req, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("mis_rst_stall", stall_out, 1'b0);
    chk1("mis_rst_err", wb_err, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;

    // Load that never completes: timeout error
    in_valid = 1; in_addr = 16'h0020; in_memread = 1; in_regwrite = 1;
    tick;
    idle_in;
    tick;
    repeat (200) tick;
    chk1("to_stall_mid", stall_out, 1'b1);
    chk1("to_err_mid", wb_err, 1'b0);
    begin
      int waited = 0;
      while (wb_err !== 1'b1 && waited < 100) begin
        tick;
        waited++;
      end
    end
    chk1("to_err", wb_err, 1'b1);
    chk1("to_wb_valid", wb_valid, 1'b1);
    chk1("to_regwrite", wb_regwrite, 1'b0);
    chk1("to_stall", stall_out, 1'b1);
    tick;
    chk1("to_stall_after", stall_out, 1'b1);
    reset_cycle;

    // Asynchronous reset in the middle of WAIT
    in_valid = 1; in_addr = 16'h5555; in_regwrite = 1;
    tick;
    in_addr = 16'h0030; in_memread = 1;
    tick;
    idle_in;
    tick;
    chk16("arw_wb_data_pre", wb_data, 16'h5555);
    chk1("arw_stall_pre", stall_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arw_stall", stall_out, 1'b0);
    chk16("arw_wb_data", wb_data, 16'h0000);
    chk1("arw_wb_valid", wb_valid, 1'b0);
    chk1("arw_req", mem_req, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;

    // Asynchronous reset while the request is being held off
    mem_stall = 1;
    in_valid = 1; in_addr = 16'h0050; in_memread = 1;
    tick;
    idle_in;
    chk1("arq_req_pre", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arq_req", mem_req, 1'b0);
    chk16("arq_addr", mem_addr, 16'h0000);
    chk1("arq_stall", stall_out, 1'b0);
    mem_stall = 0;
    tick;
    rst_n = 1'b1;
    tick;

    // Two ALU ops (second flushed) then halt
    in_valid = 1; in_addr = 16'h0001; in_regwrite = 1;
    tick;
    chk1("h_v1", wb_valid, 1'b1);
    chk16("h_d1", wb_data, 16'h0001);
    in_addr = 16'h0002; flush = 1;
    tick;
    chk1("h_v2", wb_valid, 1'b0);
    flush = 0; in_addr = 16'h0003; in_halt = 1;
    chk1("h_stall_pre", stall_out, 1'b0);
    tick;
    idle_in;
    chk1("h_v3", wb_valid, 1'b1);
    chk1("h_halt", wb_halt, 1'b1);
    chk16("h_d3", wb_data, 16'h0003);
    chk1("h_stall", stall_out, 1'b1);
    tick;
    chk1("h_v4", wb_valid, 1'b0);
    chk1("h_halt2", wb_halt, 1'b1);
    in_valid = 1; in_addr = 16'h7777; in_regwrite = 1;
    repeat (5) tick;
    chk1("h_stall_stuck", stall_out, 1'b1);
    chk1("h_v_stuck", wb_valid, 1'b0);
    chk16("h_d_stuck", wb_data, 16'h0003);
    idle_in;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
